// File: rtl/next_kms_serial_rx.sv
// Bit-serial receiver for the NeXT keyboard/mouse line: mid-bit sampling, LSB-first word, valid/ready output.
// Define NEXT_KMS_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module next_kms_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 9,
    parameter int W            = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [W-1:0]  HALF_M1  = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0]  FULL_M1  = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef NEXT_KMS_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q;
    logic                 prev_q;
    logic [W-1:0]         cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
`ifdef NEXT_KMS_RX_PARITY_EN
    logic                 par_q;
`endif

    logic                 sample_d;
    logic [DATA_BITS-1:0] shift_d;

    // START waits half a bit from the falling edge; every later state waits a full bit.
    assign sample_d = (state_q == S_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);
    assign shift_d  = {in_data, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NEXT_KMS_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            prev_q      <= in_data;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!in_data && prev_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (sample_d) begin
                        cnt_q <= '0;
                        bit_q <= '0;
`ifdef NEXT_KMS_RX_PARITY_EN
                        par_q <= 1'b0;
`endif
                        // A start bit that has gone high again by mid-bit is line noise.
                        if (in_data) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (sample_d) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
`ifdef NEXT_KMS_RX_PARITY_EN
                        par_q   <= par_q ^ in_data;
`endif
                        if (bit_q == LAST_BIT) begin
`ifdef NEXT_KMS_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

`ifdef NEXT_KMS_RX_PARITY_EN
                S_PARITY: begin
                    if (sample_d) begin
                        cnt_q   <= '0;
                        par_q   <= par_q ^ in_data;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif

                S_STOP: begin
                    if (sample_d) begin
                        cnt_q <= '0;
                        if (!in_data) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef NEXT_KMS_RX_PARITY_EN
                            if (par_q) frame_err_q <= 1'b1;
                            else
`endif
                            begin
                                // Completing while a word is still pending but being accepted is not an overrun.
                                out_data_q  <= shift_q;
                                out_valid_q <= 1'b1;
                                if (out_valid_q && !out_ready) begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_BREAK: begin
                    if (in_data) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_next_kms_serial_rx.sv
// Scoreboard bench for next_kms_serial_rx; frames are built bit by bit and expected words are queued on send.
module tb_next_kms_serial_rx;

    localparam int CPB = 16;
    localparam int DB  = 9;
`ifdef NEXT_KMS_RX_PARITY_EN
    localparam int FB  = DB + 3;
`else
    localparam int FB  = DB + 2;
`endif
    // Cycles from the first low cycle of the start bit to the first out_valid cycle.
    localparam int LAT = CPB / 2 + (FB - 1) * CPB + 1;

    typedef struct {
        logic [DB-1:0] data;
        int            t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_data = 1'b1;
    logic          out_ready = 1'b1;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   vcnt = 0, ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, acc_cnt = 0, spurious_cnt = 0;
    logic valid_prev = 1'b0;
    exp_t sb_q[$];

    next_kms_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        in_data = b;
        tick_n(CPB);
    endtask

    // Without parity compiled in, a corrupt check bit is emulated by a bad stop bit.
    function automatic logic [FB-1:0] make_frame(input logic [DB-1:0] d, input bit stop_bit, input bit par_bad);
`ifdef NEXT_KMS_RX_PARITY_EN
        return {stop_bit, (^d) ^ par_bad, d, 1'b0};
`else
        return {stop_bit & ~par_bad, d, 1'b0};
`endif
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input bit stop_bit, input bit par_bad, input bit good);
        logic [FB-1:0] f;
        exp_t          e;
        f = make_frame(d, stop_bit, par_bad);
        if (good) begin
            e.data = d;
            e.t0   = cyc;
            sb_q.push_back(e);
        end
        for (int i = 0; i < FB; i++) drive_bit(f[i]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            valid_prev <= 1'b0;
        end else begin
            valid_prev <= out_valid;
            if (out_valid && !valid_prev && sb_q.size() > 0)
                check_eq("latency", 32'(cyc - sb_q[0].t0), 32'(LAT));
            if (out_valid) vcnt <= vcnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) begin
                ovr_cnt <= ovr_cnt + 1;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
            if (out_valid && out_ready) begin
                acc_cnt <= acc_cnt + 1;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("word", 32'(out_data), 32'(e.data));
                    $display("accept data=%03h t0=%0d cyc=%0d", out_data, e.t0, cyc);
                end else begin
                    spurious_cnt <= spurious_cnt + 1;
                end
            end
        end
    end

    initial begin
        int a0, v0, f0, o0, b0;
        logic [DB-1:0] d;

        reset = 1'b1; in_data = 1'b1; out_ready = 1'b1;
        tick_n(3);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_data", 32'(out_data), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_ovr", 32'(overrun), 0);
        check_eq("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick_n(3);

        // Good frame, consumer always ready
        a0 = acc_cnt; v0 = vcnt; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(9'h1A5, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        check_eq("t1_acc", 32'(acc_cnt - a0), 1);
        check_eq("t1_valid_cycles", 32'(vcnt - v0), 1);
        check_eq("t1_ferr", 32'(ferr_cnt - f0), 0);
        check_eq("t1_ovr", 32'(ovr_cnt - o0), 0);
        check_eq("t1_data", 32'(out_data), 32'h1A5);

        // Short low glitch
        v0 = vcnt; f0 = ferr_cnt; b0 = busy_cnt;
        in_data = 1'b0;
        tick_n(4);
        in_data = 1'b1;
        tick_n(30);
        check_eq("t2_busy_cycles", 32'(busy_cnt - b0), 8);
        check_eq("t2_valid", 32'(vcnt - v0), 0);
        check_eq("t2_ferr", 32'(ferr_cnt - f0), 0);

        // Bad stop bit followed by a held-low line
        v0 = vcnt; f0 = ferr_cnt;
        send_frame(9'h0FF, 1'b0, 1'b0, 1'b0);
        in_data = 1'b0;
        tick_n(40);
        check_eq("t3_busy_low", 32'(busy), 1);
        check_eq("t3_ferr", 32'(ferr_cnt - f0), 1);
        check_eq("t3_valid", 32'(vcnt - v0), 0);
        in_data = 1'b1;
        tick_n(4);
        check_eq("t3_busy_idle", 32'(busy), 0);
        a0 = acc_cnt;
        send_frame(9'h003, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        check_eq("t3_acc", 32'(acc_cnt - a0), 1);
        check_eq("t3_data", 32'(out_data), 32'h003);

        // Overrun with consumer stalled
        out_ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(9'h011, 1'b1, 1'b0, 1'b1);
        send_frame(9'h022, 1'b1, 1'b0, 1'b1);
        tick_n(4);
        check_eq("t4_valid_held", 32'(out_valid), 1);
        check_eq("t4_data", 32'(out_data), 32'h022);
        check_eq("t4_ovr", 32'(ovr_cnt - o0), 1);
        out_ready = 1'b1;
        tick_n(1);
        out_ready = 1'b0;
        check_eq("t4_valid_clear", 32'(out_valid), 0);
        check_eq("t4_acc", 32'(acc_cnt - a0), 1);
        out_ready = 1'b1;
        tick_n(4);

        // Reset during data bit 4
        d = 9'h0AA;
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(d[k]);
        in_data = d[4];
        tick_n(8);
        reset = 1'b1;
        in_data = 1'b1;
        tick_n(1);
        check_eq("t5_rst_valid", 32'(out_valid), 0);
        check_eq("t5_rst_data", 32'(out_data), 0);
        check_eq("t5_rst_busy", 32'(busy), 0);
        check_eq("t5_rst_ferr", 32'(frame_err), 0);
        check_eq("t5_rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        tick_n(4);
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(9'h155, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        check_eq("t5_acc", 32'(acc_cnt - a0), 1);
        check_eq("t5_ferr", 32'(ferr_cnt - f0), 0);
        check_eq("t5_ovr", 32'(ovr_cnt - o0), 0);
        check_eq("t5_data", 32'(out_data), 32'h155);

`ifdef NEXT_KMS_RX_PARITY_EN
        // Parity: wrong then right check bit for 9'h001
        v0 = vcnt; f0 = ferr_cnt;
        send_frame(9'h001, 1'b1, 1'b1, 1'b0);
        tick_n(8);
        check_eq("t6_bad_ferr", 32'(ferr_cnt - f0), 1);
        check_eq("t6_bad_valid", 32'(vcnt - v0), 0);
        check_eq("t6_bad_busy", 32'(busy), 0);
        a0 = acc_cnt;
        send_frame(9'h001, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        check_eq("t6_good_acc", 32'(acc_cnt - a0), 1);
        check_eq("t6_good_data", 32'(out_data), 32'h001);
`endif

        check_eq("no_spurious", 32'(spurious_cnt), 0);
        check_eq("sb_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/next_kms_serial_rx.md
Name: next_kms_serial_rx

Overview:
Bit-serial frame receiver for the NeXT keyboard/mouse line. Consumes the already-synchronised serial input produced by the two-flop synchroniser stage and samples each bit at mid-bit. Delivers parallel words to the KMS decoder through a valid/ready handshake. Single clock domain, no internal synchroniser.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4.
DATA_BITS, 9, data bits per frame, LSB first.
W, 5, bit-counter width; 2^W > CLKS_PER_BIT required.

Ports:
clk  input  1  sole clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
in_data  input  1  synchronised serial line; idle high.
out_data  output  DATA_BITS  last received word.
out_valid  output  1  word available; held until accepted.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
frame_err  output  1  one-cycle pulse on bad stop bit (or parity, if enabled).
overrun  output  1  one-cycle pulse when a good word overwrites an unaccepted one.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; clk and reset are the only clock/reset): state IDLE, out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0, edge register prev=1, counters=0. Reset mid-frame aborts the frame silently; no error is flagged.
- Frame format: start(0), DATA_BITS data LSB first, [parity], stop(1).
- Edge detect: t0 is the first cycle with in_data==0 && prev==1, where prev is in_data registered by one cycle.
- States:
  - IDLE: on the falling edge, go to START and clear the bit counter.
  - START: at t0 + CLKS_PER_BIT/2 (integer division), sample the line. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: sample bit k (k=0..DATA_BITS-1) at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT and shift it into a DATA_BITS shift register, LSB first. After the last bit, go to PARITY if the feature is compiled in, otherwise STOP.
  - STOP: sample one CLKS_PER_BIT after the previous sample.
    - Sample 1 and no error: load out_data and set out_valid on the next cycle, then go to IDLE.
    - Sample 0: pulse frame_err, leave out_data and out_valid unchanged, go to BREAK.
  - BREAK: wait until in_data==1, then go to IDLE. A continuous low line never re-triggers reception.
- Handshake:
  - out_valid clears on the cycle after out_valid && out_ready.
  - If a good frame completes in the same cycle as acceptance, out_valid stays 1 and out_data updates. No overrun is flagged.
  - If a good frame completes while out_valid==1 and out_ready==0, out_data is overwritten, out_valid stays 1, and overrun pulses.
- Latency: out_valid rises exactly 1 cycle after the stop sample.
- The bit counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each sample point; no reachable overflow.
- Reception is back-to-back capable: the next falling edge is detected in the first IDLE cycle after STOP.

Optional Feature:
Macro: NEXT_KMS_RX_PARITY_EN.
- Defined:
  - A PARITY state samples one extra bit after the data bits.
  - The frame is good only if XOR of the data bits and the parity bit is 0 (even parity) and the stop bit is 1.
  - Parity mismatch with stop==1: pulse frame_err, no out_valid, return to IDLE.
  - Stop==0: go to BREAK as usual.
- Undefined: there is no PARITY state, and the frame is DATA_BITS+2 bits long.

Test Plan:
- Default parameters; send 9'h1A5 with correct framing and out_ready=1 → out_valid for 1 cycle at t0+8+10*16+1, out_data=9'h1A5, no flags.
- Drive in_data low for 4 cycles, then high → no out_valid, no frame_err; busy=1 for 8 cycles, then 0.
- Send 9'h0FF with stop bit 0 and line held low for 40 more cycles → one frame_err pulse, out_valid stays 0, busy stays high until the line returns high. A following 9'h003 frame is received correctly.
- out_ready=0; send 9'h011 then 9'h022 → out_valid stays 1, one overrun pulse, out_data=9'h022. Raise out_ready for 1 cycle → out_valid=0 on the next cycle.
- Assert reset at data bit 4 of a frame → all outputs 0, state IDLE. A new 9'h155 frame after reset is received with no stray flags.
- With NEXT_KMS_RX_PARITY_EN: send 9'h001 with parity bit 0 → one frame_err pulse, no out_valid. Send 9'h001 with parity bit 1 → out_data=9'h001, out_valid asserted.
